// File: rtl/gtech_oa_pipe.sv
// gtech_oa_pipe: two-stage pipelined OR-AND / AND-OR reduction cell.
// G groups of K operands, each W bits wide, are reduced bit-wise into one
// W-bit result. MODE selects OA (0), OAI (1), AO (2) or AOI (3).
//
// Handshake: a transfer on either side happens at a rising CP when that
// side's valid and ready are both high. A valid may drop without a transfer.
// Ready never depends combinationally on the valid of the same side.
// IN_RDY depends combinationally on Z_RDY only, so a full pipeline can
// accept and drain on the same edge.
module gtech_oa_pipe #(
  parameter int W = 8,
  parameter int G = 2,
  parameter int K = 2
) (
  input  logic             CP,
  input  logic             CD,
  input  logic [G*K*W-1:0] IN,
  input  logic [1:0]       MODE,
  input  logic             IN_VLD,
  output logic             IN_RDY,
  output logic [W-1:0]     Z,
  output logic             Z_VLD,
  input  logic             Z_RDY
);

  logic                s2_adv;
  logic                s1_adv;
  logic [G-1:0][W-1:0] grp_or;
  logic [G-1:0][W-1:0] grp_and;
  logic [G-1:0][W-1:0] s1_term_d;
  logic [G-1:0][W-1:0] s1_term_q;
  logic [1:0]          s1_mode_d;
  logic [1:0]          s1_mode_q;
  logic                s1_vld_d;
  logic                s1_vld_q;
  logic [W-1:0]        outer_or;
  logic [W-1:0]        outer_and;
  logic [W-1:0]        z_res;
  logic [W-1:0]        z_d;
  logic [W-1:0]        z_q;
  logic                z_vld_d;
  logic                z_vld_q;

  // Stage advance: stage 2 moves when empty or drained; stage 1 moves when
  // empty or when stage 2 makes room behind it.
  always_comb begin
    s2_adv = !z_vld_q || Z_RDY;
    s1_adv = !s1_vld_q || s2_adv;
  end

  assign IN_RDY = s1_adv;
  assign Z      = z_q;
  assign Z_VLD  = z_vld_q;

  // Inner terms of every group: both OR and AND are formed, MODE[1] picks.
  always_comb begin
    grp_or  = '0;
    grp_and = '1;
    for (int g = 0; g < G; g++) begin
      for (int k = 0; k < K; k++) begin
        grp_or[g]  = grp_or[g]  | IN[(g*K+k)*W +: W];
        grp_and[g] = grp_and[g] & IN[(g*K+k)*W +: W];
      end
    end
  end

  // Outer reduction of the registered terms, then optional inversion.
  always_comb begin
    outer_or  = '0;
    outer_and = '1;
    for (int g = 0; g < G; g++) begin
      outer_or  = outer_or  | s1_term_q[g];
      outer_and = outer_and & s1_term_q[g];
    end
    z_res = (s1_mode_q[1] ? outer_or : outer_and) ^ {W{s1_mode_q[0]}};
  end

  // Stage 1 next state: valid follows IN_VLD on advance, data only on transfer.
  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_term_d = s1_term_q;
    s1_mode_d = s1_mode_q;
    if (s1_adv) begin
      s1_vld_d = IN_VLD;
      if (IN_VLD) begin
        s1_term_d = MODE[1] ? grp_and : grp_or;
        s1_mode_d = MODE;
      end
    end
  end

  // Stage 2 next state: Z keeps its last value when the valid falls.
  always_comb begin
    z_vld_d = z_vld_q;
    z_d     = z_q;
    if (s2_adv) begin
      z_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        z_d = z_res;
      end
    end
  end

  // Pipeline registers; reset discards everything in flight.
  always_ff @(posedge CP or negedge CD) begin
    if (!CD) begin
      s1_vld_q  <= 1'b0;
      s1_term_q <= '0;
      s1_mode_q <= 2'b00;
      z_vld_q   <= 1'b0;
      z_q       <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_term_q <= s1_term_d;
      s1_mode_q <= s1_mode_d;
      z_vld_q   <= z_vld_d;
      z_q       <= z_d;
    end
  end

endmodule

// File: tb/tb_gtech_oa_pipe.sv
// Bench for gtech_oa_pipe: a 4-bit 2x2 instance for the main tests and an
// 8-bit 3x4 instance for the wider configuration.
module tb_gtech_oa_pipe;

  logic cp = 1'b0;
  logic cd = 1'b0;

  // Clock / reset
  always #5 cp = ~cp;

  logic [15:0] a_in = '0;
  logic [1:0]  a_mode = '0;
  logic        a_in_vld = 1'b0;
  logic        a_in_rdy;
  logic [3:0]  a_z;
  logic        a_z_vld;
  logic        a_z_rdy = 1'b1;

  logic [95:0] b_in = '0;
  logic [1:0]  b_mode = '0;
  logic        b_in_vld = 1'b0;
  logic        b_in_rdy;
  logic [7:0]  b_z;
  logic        b_z_vld;
  logic        b_z_rdy = 1'b1;

  gtech_oa_pipe #(.W(4), .G(2), .K(2)) u_dut_a (
    .CP(cp), .CD(cd), .IN(a_in), .MODE(a_mode), .IN_VLD(a_in_vld),
    .IN_RDY(a_in_rdy), .Z(a_z), .Z_VLD(a_z_vld), .Z_RDY(a_z_rdy)
  );

  gtech_oa_pipe #(.W(8), .G(3), .K(4)) u_dut_b (
    .CP(cp), .CD(cd), .IN(b_in), .MODE(b_mode), .IN_VLD(b_in_vld),
    .IN_RDY(b_in_rdy), .Z(b_z), .Z_VLD(b_z_vld), .Z_RDY(b_z_rdy)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] exp_q[$];
  logic [7:0] exp_b_q[$];
  logic       stall_seen = 1'b0;
  logic [3:0] prev_z = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: operands A..D are inputs 0..3; formulas straight from the truth rules.
  function automatic logic [3:0] ref_a(input logic [15:0] d, input logic [1:0] m);
    logic [3:0] a, b, c, e, r;
    a = d[3:0]; b = d[7:4]; c = d[11:8]; e = d[15:12];
    case (m)
      2'd0:    r = (a | b) & (c | e);
      2'd1:    r = ~((a | b) & (c | e));
      2'd2:    r = (a & b) | (c & e);
      default: r = ~((a & b) | (c & e));
    endcase
    return r;
  endfunction

  // Reference for the 3x4 instance, evaluated one bit lane at a time.
  function automatic logic [7:0] ref_b(input logic [95:0] d, input logic [1:0] m);
    logic [7:0] r;
    logic any_g, all_g, res, v;
    for (int bit_i = 0; bit_i < 8; bit_i++) begin
      res = !m[1];
      for (int g = 0; g < 3; g++) begin
        any_g = 1'b0;
        all_g = 1'b1;
        for (int k = 0; k < 4; k++) begin
          v = d[(g*4+k)*8 + bit_i];
          any_g = any_g | v;
          all_g = all_g & v;
        end
        if (m[1]) res = res | all_g;
        else      res = res & any_g;
      end
      r[bit_i] = res ^ m[0];
    end
    return r;
  endfunction

  // Scoreboard for instance A: push on accepted input, pop on delivered output,
  // and hold Z/Z_VLD to their stalled values.
  always @(negedge cp) begin
    if (cd && a_z_vld && a_z_rdy) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL a_unexpected: got %0h with nothing expected", a_z);
      end else begin
        check("a_result", 32'(a_z), 32'(exp_q.pop_front()));
      end
    end
    if (cd && a_in_vld && a_in_rdy) exp_q.push_back(ref_a(a_in, a_mode));
    if (cd && stall_seen) begin
      check("a_stall_z", 32'(a_z), 32'(prev_z));
      check("a_stall_vld", 32'(a_z_vld), 32'd1);
    end
    stall_seen = cd && a_z_vld && !a_z_rdy;
    prev_z = a_z;
  end

  // Scoreboard for instance B.
  always @(negedge cp) begin
    if (cd && b_z_vld && b_z_rdy) begin
      if (exp_b_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL b_unexpected: got %0h with nothing expected", b_z);
      end else begin
        check("b_result", 32'(b_z), 32'(exp_b_q.pop_front()));
      end
    end
    if (cd && b_in_vld && b_in_rdy) exp_b_q.push_back(ref_b(b_in, b_mode));
  end

  task automatic tick;
    @(posedge cp);
    #1;
  endtask

  // Driver: offer one transfer and return 1ns after the edge that took it.
  task automatic send_a(input logic [15:0] d, input logic [1:0] m, output int waited);
    logic acc;
    a_in = d;
    a_mode = m;
    a_in_vld = 1'b1;
    waited = 0;
    forever begin
      @(negedge cp);
      acc = a_in_rdy;
      @(posedge cp);
      #1;
      if (acc) break;
      waited++;
      if (waited > 50) begin
        n_checks++;
        n_errors++;
        $display("FAIL a_send_timeout: no IN_RDY within 50 cycles");
        break;
      end
    end
  endtask

  task automatic send_b(input logic [95:0] d, input logic [1:0] m);
    logic acc;
    int waited;
    b_in = d;
    b_mode = m;
    b_in_vld = 1'b1;
    waited = 0;
    forever begin
      @(negedge cp);
      acc = b_in_rdy;
      @(posedge cp);
      #1;
      if (acc) break;
      waited++;
      if (waited > 50) begin
        n_checks++;
        n_errors++;
        $display("FAIL b_send_timeout: no IN_RDY within 50 cycles");
        break;
      end
    end
    b_in_vld = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  fexp [4];
    logic [15:0] fin;
    logic [95:0] bd;
    int w;

    fexp[0] = 4'b0010; fexp[1] = 4'b1101; fexp[2] = 4'b0000; fexp[3] = 4'b1111;
    fin = {4'b0010, 4'b0100, 4'b0001, 4'b1010};

    // Reset state
    #12;
    check("rst_z_vld", 32'(a_z_vld), 32'd0);
    check("rst_z", 32'(a_z), 32'd0);
    check("rst_in_rdy", 32'(a_in_rdy), 32'd1);
    @(posedge cp);
    #3 cd = 1'b1;
    tick();

    // Four modes with fixed operands; result visible after the second edge
    for (int m = 0; m < 4; m++) begin
      send_a(fin, 2'(m), w);
      a_in_vld = 1'b0;
      check("func_early_vld", 32'(a_z_vld), 32'd0);
      tick();
      check("func_vld", 32'(a_z_vld), 32'd1);
      check("func_z", 32'(a_z), 32'(fexp[m]));
      tick();
    end

    // Streaming: 16 back-to-back transfers, no stall, continuous Z_VLD
    for (int i = 0; i < 16; i++) begin
      send_a(16'($urandom), 2'($urandom_range(0, 3)), w);
      check("stream_no_stall", 32'(w), 32'd0);
      if (i > 0) check("stream_z_vld", 32'(a_z_vld), 32'd1);
    end
    a_in_vld = 1'b0;
    tick();
    check("stream_last_vld", 32'(a_z_vld), 32'd1);
    tick();
    check("stream_empty", 32'(a_z_vld), 32'd0);

    // Backpressure: only two of three offered transfers fit
    a_z_rdy = 1'b0;
    for (int j = 0; j < 3; j++) begin
      a_in = 16'($urandom);
      a_mode = 2'($urandom_range(0, 3));
      a_in_vld = 1'b1;
      @(negedge cp);
      check("bp_in_rdy", 32'(a_in_rdy), (j < 2) ? 32'd1 : 32'd0);
      @(posedge cp);
      #1;
    end
    for (int j = 0; j < 3; j++) begin
      @(negedge cp);
      check("bp_hold_rdy", 32'(a_in_rdy), 32'd0);
      @(posedge cp);
      #1;
    end
    a_z_rdy = 1'b1;
    #1;
    check("bp_release_rdy", 32'(a_in_rdy), 32'd1);
    @(posedge cp);
    #1;
    a_in_vld = 1'b0;
    repeat (4) tick();
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Reset with both stages full
    a_z_rdy = 1'b0;
    send_a(16'($urandom), 2'($urandom_range(0, 3)), w);
    send_a(16'($urandom), 2'($urandom_range(0, 3)), w);
    a_in_vld = 1'b0;
    tick();
    check("mid_full_vld", 32'(a_z_vld), 32'd1);
    #1 cd = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_vld", 32'(a_z_vld), 32'd0);
    check("mid_rst_z", 32'(a_z), 32'd0);
    check("mid_rst_rdy", 32'(a_in_rdy), 32'd1);
    a_z_rdy = 1'b1;
    @(posedge cp);
    @(posedge cp);
    #3 cd = 1'b1;
    send_a(16'hA5C3, 2'd2, w);
    a_in_vld = 1'b0;
    check("post_rst_early", 32'(a_z_vld), 32'd0);
    tick();
    check("post_rst_vld", 32'(a_z_vld), 32'd1);
    check("post_rst_z", 32'(a_z), 32'(ref_a(16'hA5C3, 2'd2)));
    tick();
    check("post_rst_empty", 32'(a_z_vld), 32'd0);

    // Wider instance: OA with one 0xFF per group, then group 2 cleared, then AO
    bd = '0;
    for (int g = 0; g < 3; g++) bd[(g*4)*8 +: 8] = 8'hFF;
    send_b(bd, 2'd0);
    tick();
    check("gen_oa_ff", 32'(b_z), 32'h0000_00FF);
    for (int k = 0; k < 4; k++) bd[(2*4+k)*8 +: 8] = 8'h00;
    send_b(bd, 2'd0);
    tick();
    check("gen_oa_00", 32'(b_z), 32'h0000_0000);
    bd = '1;
    send_b(bd, 2'd2);
    tick();
    check("gen_ao_ff", 32'(b_z), 32'h0000_00FF);
    for (int i = 0; i < 12; i++) send_b({$urandom, $urandom, $urandom}, 2'($urandom_range(0, 3)));
    repeat (3) tick();

    // Random stress on both instances
    for (int c = 0; c < 10000; c++) begin
      a_in     = 16'($urandom);
      a_mode   = 2'($urandom_range(0, 3));
      a_in_vld = 1'($urandom_range(0, 1));
      a_z_rdy  = 1'($urandom_range(0, 1));
      b_in     = {$urandom, $urandom, $urandom};
      b_mode   = 2'($urandom_range(0, 3));
      b_in_vld = 1'($urandom_range(0, 1));
      b_z_rdy  = 1'($urandom_range(0, 1));
      tick();
    end
    a_in_vld = 1'b0;
    a_z_rdy  = 1'b1;
    b_in_vld = 1'b0;
    b_z_rdy  = 1'b1;
    repeat (5) tick();
    check("a_final_drain", 32'(exp_q.size()), 32'd0);
    check("b_final_drain", 32'(exp_b_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
